// File: rtl/alu_div_seq_if.sv
// ---------------------------------------------------------------------------
// alu_div_seq_if
//   Handshake/data bundle between the control unit and the sequential divider.
//   master : control unit side (drives start and operands, reads results)
//   slave  : divider side (reads start and operands, drives results)
//   Signals:
//     start        launch request
//     dividend     signed dividend
//     divisor      signed divisor
//     div_unsigned unsigned-divide select (only with ALU_DIV_UNSIGNED_EN)
//     busy         divide in progress
//     done         one-cycle completion pulse
//     quotient     result to LO
//     remainder    result to HI
//     div_by_zero  divisor was zero on the last completed divide
//   Optional feature macro: ALU_DIV_UNSIGNED_EN
// ---------------------------------------------------------------------------
interface alu_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef ALU_DIV_UNSIGNED_EN
  logic             div_unsigned;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
`ifdef ALU_DIV_UNSIGNED_EN
    output div_unsigned,
`endif
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
`ifdef ALU_DIV_UNSIGNED_EN
    input  div_unsigned,
`endif
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/alu_div_seq.sv
// ---------------------------------------------------------------------------
// alu_div_seq
//   Multi-cycle signed integer divider (restoring shift-subtract, one quotient
//   bit per clock). Quotient goes to LO, remainder to HI for DIV.
//   Ports:
//     clock    system clock, rising edge
//     clear_n  asynchronous active-low reset
//     div_if   alu_div_seq_if.slave (start/operands in, busy/done/results out)
//   Timing: done pulses WIDTH+2 edges after the accepting edge, or 1 edge
//   after it on divide-by-zero. busy stays high through the done cycle.
//   Optional feature macro: ALU_DIV_UNSIGNED_EN adds div_unsigned, which
//   treats both operands as unsigned and skips sign correction.
// ---------------------------------------------------------------------------
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          clear_n,
  alu_div_seq_if.slave  div_if
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_r;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quo_res;
  logic [WIDTH-1:0] r_rem_res;
  logic             r_dbz_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_t;

  // Two's-complement negate when neg is set. Negating the most negative
  // value wraps to itself, which gives the required MIN / -1 behaviour.
  function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  always_comb begin
    w_dvd_neg = div_if.dividend[WIDTH-1];
    w_dvs_neg = div_if.divisor[WIDTH-1];
`ifdef ALU_DIV_UNSIGNED_EN
    if (div_if.div_unsigned) begin
      w_dvd_neg = 1'b0;
      w_dvs_neg = 1'b0;
    end
`endif
  end

  // Partial remainder is below M, so the shifted value fits in WIDTH+1 bits
  // and the subtraction sign is bit WIDTH.
  assign w_rsh = {r_r, r_q[WIDTH-1]};
  assign w_t   = w_rsh - {1'b0, r_m};

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_r         <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quo_res   <= '0;
      r_rem_res   <= '0;
      r_dbz_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_done) begin
            // Done cycle: drop done and busy; a start here is ignored.
            r_done <= 1'b0;
            r_busy <= 1'b0;
          end else if (div_if.start) begin
            r_q     <= f_neg_if(div_if.dividend, w_dvd_neg);
            r_m     <= f_neg_if(div_if.divisor, w_dvs_neg);
            r_r     <= '0;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_cnt   <= CNT_W'(WIDTH);
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            if (div_if.divisor == '0) begin
              r_quo_res  <= '1;
              r_rem_res  <= div_if.dividend;
              r_dbz_pend <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_dbz_pend <= 1'b0;
              r_state    <= S_ITER;
            end
          end
        end
        S_ITER: begin
          if (!w_t[WIDTH]) begin
            r_r <= w_t[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= w_rsh[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quo_res <= f_neg_if(r_q, r_neg_q);
          r_rem_res <= f_neg_if(r_r, r_neg_r);
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_quotient  <= r_quo_res;
          r_remainder <= r_rem_res;
          r_dbz       <= r_dbz_pend;
          r_done      <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_if.busy        = r_busy;
  assign div_if.done        = r_done;
  assign div_if.quotient    = r_quotient;
  assign div_if.remainder   = r_remainder;
  assign div_if.div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_div_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_div_seq
//   Self-checking bench for alu_div_seq at WIDTH=32. Expected results come
//   from plain signed / and % with the divide-by-zero and MIN/-1 cases
//   written out explicitly.
// ---------------------------------------------------------------------------
module tb_alu_div_seq;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic clock;
  logic clear_n;
  int   n_checks;
  int   n_errors;

  alu_div_seq_if #(.WIDTH(W)) div_if ();

  alu_div_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .div_if  (div_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (a == MINV && b == '1) begin
      q = MINV;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  // Launch a divide and follow it to completion. poke_at >= 0 raises start
  // with (pa,pb) during that cycle of the operation; poke_done raises start
  // during the done cycle. Both must be ignored.
  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke_at, input logic [W-1:0] pa, input logic [W-1:0] pb,
                         input bit poke_done);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int lat;
    int exp_lat;
    bit busy_ok;
    model(a, b, eq, er);
    exp_lat = (b == '0) ? 1 : W + 2;
    @(negedge clock);
    div_if.start    = 1'b1;
    div_if.dividend = a;
    div_if.divisor  = b;
    @(posedge clock);
    #1;
    div_if.start    = 1'b0;
    div_if.dividend = $urandom;
    div_if.divisor  = $urandom;
    lat = 0;
    busy_ok = div_if.busy;
    while (lat < 100) begin
      if (lat == poke_at) begin
        div_if.start    = 1'b1;
        div_if.dividend = pa;
        div_if.divisor  = pb;
      end else begin
        div_if.start = 1'b0;
      end
      @(posedge clock);
      #1;
      lat++;
      if (div_if.done) break;
      if (!div_if.busy) busy_ok = 1'b0;
    end
    div_if.start = 1'b0;
    chk({name, " latency"}, W'(lat), W'(exp_lat));
    chk({name, " busy_during"}, W'(busy_ok), W'(1));
    chk({name, " busy_at_done"}, W'(div_if.busy), W'(1));
    chk({name, " quotient"}, div_if.quotient, eq);
    chk({name, " remainder"}, div_if.remainder, er);
    chk({name, " div_by_zero"}, W'(div_if.div_by_zero), W'(b == '0));
    if (poke_done) begin
      div_if.start    = 1'b1;
      div_if.dividend = 32'd9;
      div_if.divisor  = 32'd3;
    end
    @(posedge clock);
    #1;
    div_if.start = 1'b0;
    chk({name, " done_pulse"}, W'(div_if.done), W'(0));
    chk({name, " busy_after"}, W'(div_if.busy), W'(0));
    chk({name, " q_hold"}, div_if.quotient, eq);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " busy"}, W'(div_if.busy), W'(0));
    chk({name, " done"}, W'(div_if.done), W'(0));
    chk({name, " quotient"}, div_if.quotient, '0);
    chk({name, " remainder"}, div_if.remainder, '0);
    chk({name, " div_by_zero"}, W'(div_if.div_by_zero), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int seen_done;
    n_checks = 0;
    n_errors = 0;
    clear_n  = 1'b0;
    div_if.start    = 1'b0;
    div_if.dividend = '0;
    div_if.divisor  = '0;
`ifdef ALU_DIV_UNSIGNED_EN
    div_if.div_unsigned = 1'b0;
`endif
    #23;
    check_reset_state("reset");
    @(negedge clock);
    clear_n = 1'b1;

    run_div("t1_100_7", 32'd100, 32'd7, -1, '0, '0, 1'b1);
    run_div("t2_m100_7", -32'sd100, 32'd7, -1, '0, '0, 1'b0);
    run_div("t2_100_m7", 32'd100, -32'sd7, -1, '0, '0, 1'b0);
    run_div("t3_5_0", 32'd5, 32'd0, -1, '0, '0, 1'b0);
    run_div("t4_min_m1", MINV, 32'hFFFF_FFFF, -1, '0, '0, 1'b0);
    run_div("t5_1000_3", 32'd1000, 32'd3, 5, 32'd9, 32'd3, 1'b0);
    run_div("t5_9_3", 32'd9, 32'd3, -1, '0, '0, 1'b0);
    run_div("min_0", MINV, 32'd0, -1, '0, '0, 1'b0);
    run_div("min_m7", MINV, -32'sd7, -1, '0, '0, 1'b0);
    run_div("m7_m2", -32'sd7, -32'sd2, -1, '0, '0, 1'b0);

    // Reset in the middle of 1000 / 3.
    @(negedge clock);
    div_if.start    = 1'b1;
    div_if.dividend = 32'd1000;
    div_if.divisor  = 32'd3;
    @(posedge clock);
    #1;
    div_if.start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (div_if.done) seen_done++;
    end
    chk("t6 no_done_before_clear", W'(seen_done), W'(0));
    #2;
    clear_n = 1'b0;
    #1;
    check_reset_state("t6 mid_clear");
    @(negedge clock);
    clear_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (div_if.done) seen_done++;
    end
    chk("t6 no_done_after_clear", W'(seen_done), W'(0));
    run_div("t6_7_2", 32'd7, 32'd2, -1, '0, '0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: rb = -W'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 50));
      run_div("rand", ra, rb, -1, '0, '0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
